pe_tile_sched: RTL
==================

PE_TILE_SCHED -- requirements
Module: pe_tile_sched

Interface
REQ-001 SHALL have parameter MAX_K_TILES, default 16; maximum number of K-dimension tiles per command.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024; watchdog limit in the WAIT state.
REQ-003 SHALL have localparam KW = $clog2(MAX_K_TILES+1); the tile count width.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
REQ-005 SHALL have these ports:
- cmd_valid  in  1  command offered
- cmd_ready  out  1  scheduler can accept a command
- cmd_k_tiles  in  KW  number of K tiles to accumulate
- abort  in  1  synchronous abort
- tile_req_valid  out  1  request load of tile tile_req_idx
- tile_req_ready  in  1  tile operands present at PE inputs
- tile_req_idx  out  KW  current tile index
- pe_enable  out  1  PE enable
- pe_start  out  1  PE start pulse
- pe_clear  out  1  PE accumulator clear pulse
- pe_done  in  1  PE finished one tile
- res_valid  out  1  accumulated result available at PE output
- res_ready  in  1  result consumed
- busy  out  1  state != IDLE
- cmd_err  out  1  one-cycle error pulse
- tile_count  out  KW  tiles completed in the current command

Function
REQ-006 SHALL implement the states IDLE, CLEAR, FETCH, START, WAIT and RESULT.
REQ-007 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready with cmd_k_tiles in 1..MAX_K_TILES, SHALL latch k_tiles, zero tile_idx and tile_count, and go to CLEAR.
REQ-008 SHALL, in IDLE, accept cmd_k_tiles==0 or >MAX_K_TILES, pulse cmd_err for 1 cycle, stay in IDLE and drive no PE signal.
REQ-009 SHALL, in CLEAR, assert pe_clear for exactly 1 cycle and then go to FETCH.
REQ-010 SHALL, in FETCH, hold tile_req_valid=1 with stable tile_req_idx=tile_idx, and go to START on the cycle tile_req_ready=1.
REQ-011 SHALL, in START, assert pe_enable=1 and pe_start=1 for exactly 1 cycle and then go to WAIT.
REQ-012 SHALL, in WAIT, hold pe_enable=1 and sample pe_done only in WAIT; pe_done in any other state is ignored.
REQ-013 SHALL, in WAIT on pe_done, increment tile_count; if tile_idx==k_tiles-1 go to RESULT, else increment tile_idx and go to FETCH.
REQ-014 SHALL, in RESULT, hold res_valid=1 until res_ready=1, then go to IDLE; res_valid&&res_ready in the same cycle completes the command.
REQ-015 SHALL give a minimum per-tile overhead of 2 cycles (FETCH with ready already high, plus START) in addition to PE latency.
REQ-016 SHALL, on abort in any non-IDLE state, go to IDLE next cycle with all PE outputs low, no res_valid and cmd_err pulsed; abort in IDLE has no effect.
REQ-017 SHALL give abort priority over pe_done, tile_req_ready and res_ready in the same cycle.
REQ-018 SHALL drive all outputs registered or purely state-decoded, with no combinational path from cmd_valid to PE outputs.

Reset
REQ-019 SHALL, on rst_n low, immediately enter IDLE with cmd_ready=1 and tile_req_idx=0, tile_count=0, and all other outputs 0.
REQ-020 SHALL, on reset mid-command, discard the command; the first cycle after release is IDLE.

Configuration
REQ-021 SHALL, when PE_TILE_SCHED_TIMEOUT_EN is defined, count cycles in WAIT; if the count reaches TIMEOUT_CYCLES without pe_done, pulse cmd_err and go to IDLE, with the counter zeroed on every WAIT entry.
REQ-022 SHALL, when PE_TILE_SCHED_TIMEOUT_EN is undefined, contain no counter and wait in WAIT indefinitely.

Structure
REQ-023 SHALL place the state enum pe_sched_state_t (3-bit) in shared package npu_pkg.
REQ-024 SHALL place the watchdog in sub-module pe_sched_watchdog, instantiated only under the macro.

Verification
REQ-025 SHALL cover: k_tiles=3, tile_req_ready always 1, pe_done 4 cycles after pe_start -> 1 pe_clear, 3 pe_start pulses, tile_req_idx 0,1,2, res_valid after the 3rd pe_done, tile_count=3.
REQ-026 SHALL cover: cmd_k_tiles=0 -> cmd_err 1 cycle, cmd_ready stays 1, no pe_clear or pe_start.
REQ-027 SHALL cover: k_tiles=2, tile_req_ready delayed 5 cycles -> tile_req_valid held 5 cycles, idx stable, pe_start only after ready.
REQ-028 SHALL cover: res_ready held low 10 cycles -> res_valid held 10 cycles, cmd_ready=0 throughout, then IDLE.
REQ-029 SHALL cover: abort in WAIT of tile 1 of 4, with pe_done in the same cycle -> IDLE next cycle, cmd_err=1, no res_valid.
REQ-030 SHALL cover: with the macro and TIMEOUT_CYCLES=8, pe_done never arrives -> cmd_err 8 cycles after WAIT entry, then IDLE.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: state encoding for the PE tile scheduler.
package npu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FETCH  = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_RESULT = 3'd5
  } pe_sched_state_t;

endpackage

// File: rtl/pe_sched_watchdog.sv
// WAIT-state watchdog for pe_tile_sched, only built with PE_TILE_SCHED_TIMEOUT_EN.
// The count restarts from zero whenever the scheduler is outside WAIT, so
// every WAIT entry gets a fresh TIMEOUT_CYCLES budget.
module pe_sched_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_wait,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count WAIT cycles; hold at the last value so the compare stays asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!in_wait) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Expiry is flagged during the TIMEOUT_CYCLES-th WAIT cycle; the scheduler
  // leaves WAIT at the following edge.
  assign expired = in_wait && (cnt == LAST);

endmodule

// File: rtl/pe_tile_sched.sv
// PE tile scheduler: accumulates cmd_k_tiles K tiles on one PE per command.
// Optional WAIT watchdog: define PE_TILE_SCHED_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | ready for a command; bad tile counts pulse cmd_err here
//   CLEAR  | one-cycle accumulator clear
//   FETCH  | request operands for tile tile_idx, wait for tile_req_ready
//   START  | one-cycle PE start
//   WAIT   | PE running, waiting for pe_done
//   RESULT | accumulated result offered until res_ready
module pe_tile_sched
  import npu_pkg::*;
#(
  parameter int MAX_K_TILES    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int KW            = $clog2(MAX_K_TILES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [KW-1:0] cmd_k_tiles,
  input  logic          abort,
  output logic          tile_req_valid,
  input  logic          tile_req_ready,
  output logic [KW-1:0] tile_req_idx,
  output logic          pe_enable,
  output logic          pe_start,
  output logic          pe_clear,
  input  logic          pe_done,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          busy,
  output logic          cmd_err,
  output logic [KW-1:0] tile_count
);

  localparam logic [KW-1:0] K_MAX = KW'(MAX_K_TILES);

  pe_sched_state_t state, state_nxt;
  logic [KW-1:0]   k_tiles;
  logic [KW-1:0]   tile_idx;
  logic            err_nxt;
  logic            timeout;
  logic            cmd_ok;
  logic            last_tile;

  assign cmd_ok    = (cmd_k_tiles != '0) && (cmd_k_tiles <= K_MAX);
  assign last_tile = (tile_idx == k_tiles - 1'b1);

`ifdef PE_TILE_SCHED_TIMEOUT_EN
  pe_sched_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_wait(state == S_WAIT),
    .expired(timeout)
  );
`else
  // No watchdog: WAIT is left only on pe_done or abort.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and state-decoded outputs; abort overrides every other event.
  always_comb begin
    state_nxt      = state;
    err_nxt        = 1'b0;
    cmd_ready      = 1'b0;
    tile_req_valid = 1'b0;
    pe_enable      = 1'b0;
    pe_start       = 1'b0;
    pe_clear       = 1'b0;
    res_valid      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_ok) state_nxt = S_CLEAR;
          else        err_nxt   = 1'b1;
        end
      end
      S_CLEAR: begin
        pe_clear  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        tile_req_valid = 1'b1;
        if (tile_req_ready) state_nxt = S_START;
      end
      S_START: begin
        pe_enable = 1'b1;
        pe_start  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        pe_enable = 1'b1;
        if (pe_done) begin
          state_nxt = last_tile ? S_RESULT : S_FETCH;
        end else if (timeout) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      err_nxt   = 1'b1;
    end
  end

  // Command latch, tile bookkeeping and the registered error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_tiles    <= '0;
      tile_idx   <= '0;
      tile_count <= '0;
      cmd_err    <= 1'b0;
    end else begin
      cmd_err <= err_nxt;
      if ((state == S_IDLE) && cmd_valid && cmd_ok) begin
        k_tiles    <= cmd_k_tiles;
        tile_idx   <= '0;
        tile_count <= '0;
      end else if ((state == S_WAIT) && pe_done && !abort) begin
        tile_count <= tile_count + 1'b1;
        if (!last_tile) tile_idx <= tile_idx + 1'b1;
      end
    end
  end

  assign tile_req_idx = tile_idx;
  assign busy         = (state != S_IDLE);

endmodule
